// File: rtl/gen_sched.sv
// Generation scheduler: waits out monitor warm-up, then hands cell storage to the
// update engine once per N frames (or per step), aborting if vblank ends first.
module gen_sched #(
    parameter int WARMUP_FRAMES = 320,
    parameter int GEN_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             vblank,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       period,
    output logic             upd_start,
    input  logic             upd_done,
    output logic             upd_abort,
    output logic             sel_engine,
    output logic [GEN_W-1:0] gen_count,
    output logic             warm
);

    localparam int WU_W = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        IDLE   = 2'd1,
        UPDATE = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [3:0]        frm_cnt, frm_n;
    logic [WU_W-1:0]   wu_cnt, wu_n;
    logic              step_pend, step_n;
    logic              retry, retry_n;
    logic [GEN_W-1:0]  gen_n;

    logic [3:0]        per;
    logic [4:0]        frm_inc;
    logic              hit;
    logic              wu_last;

    assign per     = (period == 4'd0) ? 4'd1 : period;
    assign frm_inc = {1'b0, frm_cnt} + 5'd1;
    assign hit     = run && (frm_inc == {1'b0, per});
    assign wu_last = (WARMUP_FRAMES <= 1) ? 1'b1 : (wu_cnt == WU_W'(WARMUP_FRAMES - 1));

    always_comb begin
        state_n = state;
        frm_n   = frm_cnt;
        wu_n    = wu_cnt;
        step_n  = step_pend;
        retry_n = retry;
        gen_n   = gen_count;
        case (state)
            WARMUP: begin
                if (frame_start) begin
                    if (wu_last) state_n = IDLE;
                    else         wu_n    = wu_cnt + WU_W'(1);
                end
            end
            IDLE: begin
                if (step) step_n = 1'b1;
                if (frame_start) begin
                    // A pending step or retry forces a generation; the frame counter
                    // only restarts if it happened to hit its terminal count too.
                    if (step_pend || retry) begin
                        state_n = UPDATE;
                        frm_n   = hit ? 4'd0 : frm_cnt;
                    end else if (hit) begin
                        state_n = UPDATE;
                        frm_n   = 4'd0;
                    end else if (run) begin
                        frm_n = frm_inc[3:0];
                    end
                    if (state_n == UPDATE) begin
                        step_n  = 1'b0;
                        retry_n = 1'b0;
                    end
                end else if (frm_cnt >= per) begin
                    frm_n = 4'd0;
                end
            end
            UPDATE: begin
                if (step) step_n = 1'b1;
                if (frm_cnt >= per) frm_n = 4'd0;
                // A commit arriving as vblank ends still counts.
                if (upd_done) begin
                    gen_n   = gen_count + GEN_W'(1);
                    state_n = IDLE;
                end else if (!vblank) begin
                    retry_n = 1'b1;
                    state_n = ABORT;
                end
            end
            ABORT: begin
                state_n = IDLE;
            end
            default: state_n = WARMUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WARMUP;
            frm_cnt    <= 4'd0;
            wu_cnt     <= '0;
            step_pend  <= 1'b0;
            retry      <= 1'b0;
            gen_count  <= '0;
            upd_start  <= 1'b0;
            upd_abort  <= 1'b0;
            sel_engine <= 1'b0;
            warm       <= 1'b0;
        end else begin
            state      <= state_n;
            frm_cnt    <= frm_n;
            wu_cnt     <= wu_n;
            step_pend  <= step_n;
            retry      <= retry_n;
            gen_count  <= gen_n;
            upd_start  <= (state == IDLE) && (state_n == UPDATE);
            upd_abort  <= (state_n == ABORT);
            sel_engine <= (state_n == UPDATE);
            warm       <= (state_n != WARMUP);
        end
    end

endmodule

// File: tb/tb_gen_sched.sv
// Directed bench for gen_sched: warm-up, period, step, abort/retry, tie, reset and wrap.
module tb_gen_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       vblank = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] period = 4'd1;
    logic       upd_start;
    logic       upd_done = 1'b0;
    logic       upd_abort;
    logic       sel_engine;
    logic [3:0] gen_count;
    logic       warm;

    int checks = 0;
    int errors = 0;

    gen_sched #(.WARMUP_FRAMES(2), .GEN_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .vblank     (vblank),
        .run        (run),
        .step       (step),
        .period     (period),
        .upd_start  (upd_start),
        .upd_done   (upd_done),
        .upd_abort  (upd_abort),
        .sel_engine (sel_engine),
        .gen_count  (gen_count),
        .warm       (warm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic pulse_done();
        upd_done = 1'b1;
        tick();
        upd_done = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset state
        ticks(2);
        check("rst_warm", 32'(warm), 32'd0);
        check("rst_sel", 32'(sel_engine), 32'd0);
        check("rst_gen", 32'(gen_count), 32'd0);
        check("rst_start", 32'(upd_start), 32'd0);
        check("rst_abort", 32'(upd_abort), 32'd0);
        rst = 1'b0;
        tick();

        // warm-up: two frames ignored, third triggers
        run = 1'b1; period = 4'd1; vblank = 1'b1;
        pulse_step();
        pulse_fs();
        check("wu1_warm", 32'(warm), 32'd0);
        check("wu1_start", 32'(upd_start), 32'd0);
        ticks(3);
        pulse_fs();
        check("wu2_warm", 32'(warm), 32'd1);
        check("wu2_start", 32'(upd_start), 32'd0);
        ticks(3);
        pulse_fs();
        check("wu3_start", 32'(upd_start), 32'd1);
        check("wu3_sel", 32'(sel_engine), 32'd1);
        tick();
        check("wu3_start_once", 32'(upd_start), 32'd0);
        check("wu3_sel_hold", 32'(sel_engine), 32'd1);
        pulse_done();
        check("wu3_gen", 32'(gen_count), 32'd1);
        check("wu3_sel_rel", 32'(sel_engine), 32'd0);

        // period 3, done 10 cycles after start
        period = 4'd3;
        ticks(2);
        for (int f = 0; f < 9; f++) begin
            pulse_fs();
            check($sformatf("per_f%0d", f), 32'(upd_start), (f % 3 == 2) ? 32'd1 : 32'd0);
            if (upd_start) begin
                ticks(9);
                pulse_done();
                ticks(5);
            end else begin
                ticks(15);
            end
        end
        check("per_gen", 32'(gen_count), 32'd4);

        // step while paused: two steps collapse to one generation
        run = 1'b0;
        pulse_step();
        tick();
        pulse_step();
        ticks(2);
        pulse_fs();
        check("step_start", 32'(upd_start), 32'd1);
        ticks(2);
        pulse_done();
        check("step_gen", 32'(gen_count), 32'd5);
        ticks(2);
        pulse_fs();
        check("step_again_start", 32'(upd_start), 32'd0);
        check("step_again_sel", 32'(sel_engine), 32'd0);

        // abort then retry with run=0
        pulse_step();
        pulse_fs();
        check("ab_start", 32'(upd_start), 32'd1);
        tick();
        vblank = 1'b0;
        tick();
        check("ab_abort", 32'(upd_abort), 32'd1);
        check("ab_sel", 32'(sel_engine), 32'd0);
        tick();
        check("ab_abort_once", 32'(upd_abort), 32'd0);
        check("ab_gen", 32'(gen_count), 32'd5);
        vblank = 1'b1;
        ticks(2);
        pulse_fs();
        check("retry_start", 32'(upd_start), 32'd1);
        ticks(2);
        pulse_done();
        check("retry_gen", 32'(gen_count), 32'd6);
        ticks(2);
        pulse_done();
        check("idle_done_ignored", 32'(gen_count), 32'd6);

        // done and vblank fall together: done wins
        pulse_step();
        pulse_fs();
        tick();
        upd_done = 1'b1; vblank = 1'b0;
        tick();
        upd_done = 1'b0;
        check("tie_gen", 32'(gen_count), 32'd7);
        check("tie_abort", 32'(upd_abort), 32'd0);
        check("tie_sel", 32'(sel_engine), 32'd0);
        tick();
        check("tie_abort_later", 32'(upd_abort), 32'd0);
        vblank = 1'b1;
        ticks(2);

        // asynchronous reset mid-update
        pulse_step();
        pulse_fs();
        check("rmid_sel_before", 32'(sel_engine), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rmid_sel", 32'(sel_engine), 32'd0);
        check("rmid_gen", 32'(gen_count), 32'd0);
        check("rmid_warm", 32'(warm), 32'd0);
        check("rmid_abort", 32'(upd_abort), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // counter wrap with 4-bit gen_count
        run = 1'b1; period = 4'd1;
        pulse_fs();
        ticks(2);
        pulse_fs();
        check("wrap_warm", 32'(warm), 32'd1);
        check("wrap_no_start", 32'(upd_start), 32'd0);
        ticks(2);
        for (int g = 0; g < 16; g++) begin
            pulse_fs();
            check($sformatf("wrap_start%0d", g), 32'(upd_start), 32'd1);
            tick();
            pulse_done();
            if (g == 14) check("wrap_gen15", 32'(gen_count), 32'd15);
            ticks(2);
        end
        check("wrap_gen0", 32'(gen_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gen_sched.md
GEN_SCHED -- requirements
Module: gen_sched

Interface
REQ-001 SHALL have parameter WARMUP_FRAMES, default 320: frame_start pulses to ignore after reset (monitor sync time).
REQ-002 SHALL have parameter GEN_W, default 16: width of the generation counter.
REQ-003 SHALL have port clk  input  1: single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1: one-cycle pulse on the first cycle of vertical blanking.
REQ-006 SHALL have port vblank  input  1: high for the whole vertical-blanking interval.
REQ-007 SHALL have port run  input  1: level; high = free-running generations.
REQ-008 SHALL have port step  input  1: one-cycle pulse; requests exactly one generation.
REQ-009 SHALL have port period  input  4: frames per generation; 0 is treated as 1.
REQ-010 SHALL have port upd_start  output  1: one-cycle start pulse to the cell-update engine.
REQ-011 SHALL have port upd_done  input  1: one-cycle pulse from the engine when the generation is committed.
REQ-012 SHALL have port upd_abort  output  1: one-cycle pulse telling the engine to discard its partial generation.
REQ-013 SHALL have port sel_engine  output  1: cell-storage mux select; 1 = engine owns storage, 0 = display reader owns it.
REQ-014 SHALL have port gen_count  output  GEN_W: number of committed generations.
REQ-015 SHALL have port warm  output  1: high once warm-up has completed.

Function
REQ-016 SHALL implement the states WARMUP, IDLE, UPDATE and ABORT.
REQ-017 WARMUP SHALL count frame_start pulses and move to IDLE on the cycle after the WARMUP_FRAMES-th pulse; warm SHALL be 1 from that cycle on.
REQ-018 WARMUP SHALL ignore run and step, so no step is latched during warm-up.
REQ-019 In IDLE with run=1, each frame_start SHALL increment frm_cnt.
REQ-020 When the incremented frm_cnt equals max(period,1), the scheduler SHALL clear frm_cnt and enter UPDATE on the next cycle.
REQ-021 A step pulse in IDLE or UPDATE SHALL set step_pend; multiple steps before consumption SHALL collapse into one.
REQ-022 In IDLE, frame_start with step_pend=1 or retry=1 SHALL enter UPDATE regardless of run and frm_cnt.
REQ-023 Entering UPDATE from IDLE SHALL clear step_pend and retry; frm_cnt SHALL be left unchanged unless REQ-020 applied.
REQ-024 upd_start SHALL be 1 for exactly the first cycle in UPDATE, i.e. one cycle after the triggering frame_start.
REQ-025 sel_engine SHALL be 1 exactly while in UPDATE; the display side owns storage in every other state.
REQ-026 In UPDATE, upd_done=1 SHALL increment gen_count (wrapping from all-ones to 0) and return to IDLE on the next cycle.
REQ-027 In UPDATE, vblank=0 with upd_done=0 SHALL move to ABORT, setting retry=1 and leaving gen_count unchanged.
REQ-028 If upd_done=1 and vblank=0 occur in the same cycle, done SHALL win and REQ-026 SHALL apply.
REQ-029 ABORT SHALL last one cycle: upd_abort=1 and sel_engine=0, then IDLE.
REQ-030 upd_done while not in UPDATE SHALL be ignored.
REQ-031 A frame_start while in UPDATE or ABORT SHALL be ignored and SHALL NOT increment frm_cnt.
REQ-032 Changing period mid-count SHALL take effect at the next compare, using an equality test, and SHALL clear frm_cnt if frm_cnt >= the new period.
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 Asserting rst at any time, including mid-UPDATE, SHALL immediately force state=WARMUP, frm_cnt=0, warmup count=0, step_pend=0, retry=0, gen_count=0, upd_start=0, upd_abort=0, sel_engine=0 and warm=0.
REQ-035 Reset SHALL NOT pulse upd_abort; the engine shares rst and clears itself.
REQ-036 The first frame_start counted after reset SHALL be the first one sampled with rst low.

Verification
REQ-037 SHALL cover warm-up: WARMUP_FRAMES=2, run=1, period=1, 3 frame_starts -> upd_start only after the 3rd; warm rises after the 2nd.
REQ-038 SHALL cover period: period=3, run=1, upd_done 10 cycles after each upd_start, 9 frames -> 3 upd_starts, gen_count=3.
REQ-039 SHALL cover step while paused: run=0, two step pulses, then frame_start -> exactly one upd_start; a second frame_start -> none.
REQ-040 SHALL cover abort and retry: vblank drops before upd_done -> upd_abort pulse, gen_count unchanged; next frame_start -> upd_start even with run=0.
REQ-041 SHALL cover the tie: upd_done and vblank fall in the same cycle -> gen_count+1 and no upd_abort.
REQ-042 SHALL cover reset mid-operation: rst during UPDATE -> sel_engine=0 and gen_count=0 immediately (asynchronously); with GEN_W=4, 16 generations -> gen_count wraps to 0.
